// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth product accumulator.
package booth_pkg;

    localparam int PROD_W = 16;
    // Widest accumulator the sign-extension helper supports.
    localparam int SEXT_W = 64;

    typedef enum logic {ST_ACC, ST_DONE} mac_state_t;

    function automatic logic [SEXT_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(SEXT_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed W-bit adder with overflow flag.
// MAC_SAT_EN defined: clamp to the signed range on overflow; otherwise wrap.
module mac_sat_add
#(
    parameter int W = 32
)
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    import booth_pkg::*;

    logic [W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef MAC_SAT_EN
        sum = raw;
        if (ovf) begin
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Accumulates signed 16-bit products into one ACC_W-bit sum per frame.
// MAC_SAT_EN selects saturating rather than wrapping accumulation.
module booth_mac_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W     = 32,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    mac_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             in_xfer;
    logic             close;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_next;

    assign prod_ext = ACC_W'(sext_prod(in_product));

    mac_sat_add #(.W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready  = (state_q == ST_ACC) && !rst;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        in_xfer  = in_valid && in_ready;
        cnt_inc  = cnt_q + CNT_W'(1);
        ovf_next = ovf_q | add_ovf;
        close    = in_xfer && (in_last || (cnt_inc == CNT_W'(MAX_TERMS)));

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        // clear outranks both the input transfer and the output handshake
        if (clear) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (close) begin
                        out_acc_d   = add_sum;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_DONE;
                    end else if (in_xfer) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_next;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench: a 16-bit/4-term instance (index 0) and a default 32-bit instance (index 1).
module tb_booth_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear      [2];
    logic        in_valid   [2];
    logic        in_last    [2];
    logic        out_ready  [2];
    logic [15:0] in_product [2];
    logic        in_ready   [2];
    logic        out_valid  [2];
    logic        out_ovf    [2];

    logic [15:0] out_acc_a;
    logic [2:0]  out_count_a;
    logic [31:0] out_acc_b;
    logic [8:0]  out_count_b;

    int acc_s [2];
    int cnt_s [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.ACC_W(16), .MAX_TERMS(4), .CNT_W(3)) u_small (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .in_product (in_product[0]),
        .in_last    (in_last[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_acc    (out_acc_a),
        .out_count  (out_count_a),
        .out_ovf    (out_ovf[0])
    );

    booth_mac_accumulator #(.ACC_W(32), .MAX_TERMS(256), .CNT_W(9)) u_wide (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .in_product (in_product[1]),
        .in_last    (in_last[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_acc    (out_acc_b),
        .out_count  (out_count_b),
        .out_ovf    (out_ovf[1])
    );

    always_comb begin
        acc_s[0] = int'($signed(out_acc_a));
        acc_s[1] = int'($signed(out_acc_b));
        cnt_s[0] = int'(out_count_a);
        cnt_s[1] = int'(out_count_b);
    end

    typedef struct {
        int dut;
        int n;
        int prod [4];
        int exp_acc;
        int exp_cnt;
        int exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int p, input logic last);
        in_valid[d]   = 1'b1;
        in_product[d] = 16'(p);
        in_last[d]    = last;
        step();
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic check_result(input int d, input string tag, input int a, input int c, input int o);
        chk({tag, " out_valid"}, int'(out_valid[d]), 1);
        chk({tag, " out_acc"},   acc_s[d], a);
        chk({tag, " out_count"}, cnt_s[d], c);
        chk({tag, " out_ovf"},   int'(out_ovf[d]), o);
        chk({tag, " in_ready"},  int'(in_ready[d]), 0);
    endtask

    task automatic drain(input int d, input string tag);
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        chk({tag, " drained out_valid"}, int'(out_valid[d]), 0);
        chk({tag, " drained in_ready"},  int'(in_ready[d]), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 3, '{300, -50, 1000, 0},          1250,   3, 0};
        vecs[1] = '{1, 3, '{-32768, -32768, -32768, 0}, -98304, 3, 0};
        vecs[2] = '{1, 2, '{32767, 1, 0, 0},             32768,  2, 0};
        vecs[3] = '{1, 1, '{-5, 0, 0, 0},                -5,     1, 0};
`ifdef MAC_SAT_EN
        vecs[4] = '{0, 2, '{28672, 28672, 0, 0},         32767,  2, 1};
        vecs[5] = '{0, 2, '{-32768, -1, 0, 0},           -32768, 2, 1};
        vecs[6] = '{0, 3, '{28672, 28672, 8192, 0},      32767,  3, 1};
`else
        vecs[4] = '{0, 2, '{28672, 28672, 0, 0},         -8192,  2, 1};
        vecs[5] = '{0, 2, '{-32768, -1, 0, 0},           32767,  2, 1};
        vecs[6] = '{0, 3, '{28672, 28672, 8192, 0},      0,      3, 1};
`endif
        vecs[7] = '{0, 4, '{1, 2, 3, 4},                 10,     4, 0};
        vecs[8] = '{0, 2, '{100, -100, 0, 0},            0,      2, 0};

        for (int d = 0; d < 2; d++) begin
            clear[d]      = 1'b0;
            in_valid[d]   = 1'b0;
            in_last[d]    = 1'b0;
            out_ready[d]  = 1'b0;
            in_product[d] = '0;
        end
        rst = 1'b1;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready",  int'(in_ready[d]), 0);
            chk("reset out_valid", int'(out_valid[d]), 0);
            chk("reset out_acc",   acc_s[d], 0);
            chk("reset out_count", cnt_s[d], 0);
            chk("reset out_ovf",   int'(out_ovf[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post-reset in_ready 0", int'(in_ready[0]), 1);
        chk("post-reset in_ready 1", int'(in_ready[1]), 1);

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                send(vecs[v].dut, vecs[v].prod[i], (i == vecs[v].n - 1));
                if (i != vecs[v].n - 1)
                    chk($sformatf("vec%0d early out_valid", v), int'(out_valid[vecs[v].dut]), 0);
            end
            check_result(vecs[v].dut, $sformatf("vec%0d", v),
                         vecs[v].exp_acc, vecs[v].exp_cnt, vecs[v].exp_ovf);
            drain(vecs[v].dut, $sformatf("vec%0d", v));
        end

        // Backpressure: result held, a pending product is not taken while DONE.
        send(1, 5, 1'b0);
        send(1, 6, 1'b1);
        in_valid[1]   = 1'b1;
        in_product[1] = 16'(99);
        in_last[1]    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_result(1, $sformatf("stall%0d", k), 11, 2, 0);
            step();
        end
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        chk("stall release out_valid", int'(out_valid[1]), 0);
        chk("stall release in_ready",  int'(in_ready[1]), 1);
        step();
        in_valid[1] = 1'b0;
        in_last[1]  = 1'b0;
        check_result(1, "after stall", 99, 1, 0);
        drain(1, "after stall");

        // Forced close at MAX_TERMS=4; next frame starts with the 5th product.
        for (int i = 0; i < 4; i++) begin
            chk("maxterm pre out_valid", int'(out_valid[0]), 0);
            send(0, 1, 1'b0);
        end
        check_result(0, "maxterm", 4, 4, 0);
        drain(0, "maxterm");
        send(0, 1, 1'b0);
        send(0, 1, 1'b0);
        chk("maxterm tail out_valid", int'(out_valid[0]), 0);
        send(0, 1, 1'b1);
        check_result(0, "maxterm next", 3, 3, 0);
        drain(0, "maxterm next");

        // Async reset mid-frame discards the partial sum.
        send(1, 4, 1'b0);
        send(1, 8, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst in_ready",  int'(in_ready[1]), 0);
        chk("midrst out_valid", int'(out_valid[1]), 0);
        chk("midrst out_acc",   acc_s[1], 0);
        step();
        rst = 1'b0;
        step();
        chk("midrst released in_ready", int'(in_ready[1]), 1);
        send(1, 7, 1'b1);
        check_result(1, "midrst", 7, 1, 0);
        drain(1, "midrst");

        // clear beats a simultaneous closing transfer.
        clear[1]      = 1'b1;
        in_valid[1]   = 1'b1;
        in_product[1] = 16'(9);
        in_last[1]    = 1'b1;
        step();
        clear[1]    = 1'b0;
        in_valid[1] = 1'b0;
        in_last[1]  = 1'b0;
        chk("clear drop out_valid", int'(out_valid[1]), 0);
        chk("clear drop in_ready",  int'(in_ready[1]), 1);
        send(1, 5, 1'b1);
        check_result(1, "clear drop", 5, 1, 0);
        drain(1, "clear drop");

        // clear in DONE flushes the pending result but out_acc keeps its value.
        send(1, 3, 1'b1);
        chk("clear done pre out_valid", int'(out_valid[1]), 1);
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        chk("clear done out_valid", int'(out_valid[1]), 0);
        chk("clear done in_ready",  int'(in_ready[1]), 1);
        chk("clear done out_acc",   acc_s[1], 3);
        send(1, 2, 1'b1);
        check_result(1, "after clear done", 2, 1, 0);
        drain(1, "after clear done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
